hs_monitor: RTL and testbench

Synthesizable valid/ready handshake monitor that watches one channel and emits structured event records (level, topic, timestamp, cycle count, data) into a small on-chip FIFO drained over its own valid/ready port. It is the in-hardware counterpart of the simulation event log: the same stability, withdrawal and observe-timeout checks, evaluated cycle-by-cycle in RTL. It sits beside any streaming interface, either in debug builds or in benches where the event stream is read back by the host.

---
 rtl/hs_monitor_pkg.sv | 27 ++
 rtl/hs_monitor_event_fifo.sv | 57 +++++
 rtl/hs_monitor.sv | 181 ++++++++++++++++++
 tb/tb_hs_monitor.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/hs_monitor_pkg.sv
// Shared type definitions for the handshake monitor: event tone, event topic
// and the monitor FSM state encoding.
package hs_monitor_pkg;

    typedef enum logic [2:0] {
        TONE_TRACE = 3'd0,
        TONE_DEBUG = 3'd1,
        TONE_INFO  = 3'd2,
        TONE_WARN  = 3'd3,
        TONE_ERROR = 3'd4,
        TONE_FATAL = 3'd5
    } tone_e;

    typedef enum logic [1:0] {
        TOPIC_HANDSHAKE = 2'd0,
        TOPIC_STBL      = 2'd1,
        TOPIC_WITHDRAW  = 2'd2,
        TOPIC_TIMEOUT   = 2'd3
    } topic_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_STUCK = 2'd2
    } mon_state_e;

endpackage

// File: rtl/hs_monitor_event_fifo.sv
// First-word-fall-through FIFO for packed event records. Pointers carry one
// extra wrap bit so full and empty are told apart without a separate counter.
module event_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_full
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW:0]      r_wr;
    logic [PW:0]      r_rd;
    logic             w_empty;
    logic             w_full;
    logic             w_do_pop;
    logic             w_do_push;

    assign w_empty   = (r_wr == r_rd);
    assign w_full    = (r_wr[PW] != r_rd[PW]) && (r_wr[PW-1:0] == r_rd[PW-1:0]);
    // A pop frees a slot in the same cycle, so a push at full is still taken.
    assign w_do_pop  = i_pop & ~w_empty;
    assign w_do_push = i_push & (~w_full | w_do_pop);

    assign o_valid = ~w_empty;
    assign o_full  = w_full;
    assign o_data  = r_mem[r_rd[PW-1:0]];

    // Advance read and write pointers on accepted pop/push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + 1'b1;
            if (w_do_pop)  r_rd <= r_rd + 1'b1;
        end
    end

    // Storage; cleared on reset so the head reads all-zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_do_push) begin
            r_mem[r_wr[PW-1:0]] <= i_data;
        end
    end

endmodule

// File: rtl/hs_monitor.sv
// Valid/ready handshake monitor. Checks payload stability, valid withdrawal
// and stall timeout on one channel and queues one event record per cycle at
// most into a small FWFT FIFO, counting records lost while the FIFO is full.
module hs_monitor
    import hs_monitor_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int TIMEOUT    = 16,
    parameter int TS_WIDTH   = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mon_valid,
    input  logic                  mon_ready,
    input  logic [DATA_WIDTH-1:0] mon_data,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic [2:0]            evt_level,
    output logic [1:0]            evt_topic,
    output logic [TS_WIDTH-1:0]   evt_time,
    output logic [CNT_WIDTH-1:0]  evt_cycles,
    output logic [DATA_WIDTH-1:0] evt_data,
    output logic [CNT_WIDTH-1:0]  drop_count
);

    typedef struct packed {
        tone_e                 level;
        topic_e                topic;
        logic [TS_WIDTH-1:0]   tstamp;
        logic [CNT_WIDTH-1:0]  cycles;
        logic [DATA_WIDTH-1:0] data;
    } event_t;

    localparam int EVT_W = $bits(event_t);
    localparam logic [CNT_WIDTH-1:0] TMO_CNT = CNT_WIDTH'(TIMEOUT);

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    mon_state_e            r_state;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [DATA_WIDTH-1:0] r_lat;
    logic [TS_WIDTH-1:0]   r_ts;
    logic [CNT_WIDTH-1:0]  r_drop;

    logic [CNT_WIDTH-1:0]  w_cnt_nxt;
    logic                  w_active;
    logic                  w_withdraw;
    logic                  w_stbl;
    logic                  w_hs_hold;
    logic                  w_hs_idle;
    logic                  w_tmo;
    logic                  w_evt;
    event_t                w_rec;
    event_t                w_head;
    logic [EVT_W-1:0]      w_head_bits;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;

    // Event qualifiers in priority order; each excludes the ones above it.
    assign w_cnt_nxt  = sat_inc(r_cnt);
    assign w_active   = (r_state != ST_IDLE);
    assign w_withdraw = w_active & ~mon_valid;
    assign w_stbl     = w_active & mon_valid & (mon_data != r_lat);
    assign w_hs_hold  = w_active & mon_valid & mon_ready & (mon_data == r_lat);
    assign w_tmo      = (r_state == ST_HOLD) & mon_valid & ~mon_ready &
                        (mon_data == r_lat) & (w_cnt_nxt >= TMO_CNT);
    assign w_hs_idle  = (r_state == ST_IDLE) & mon_valid & mon_ready;
    assign w_evt      = w_withdraw | w_stbl | w_hs_hold | w_tmo | w_hs_idle;

    // Build the record for whichever event fires this cycle.
    always_comb begin
        w_rec        = '0;
        w_rec.tstamp = r_ts;
        if (w_hs_idle) begin
            w_rec.level  = TONE_INFO;
            w_rec.topic  = TOPIC_HANDSHAKE;
            w_rec.cycles = CNT_WIDTH'(1);
            w_rec.data   = mon_data;
        end else if (w_withdraw) begin
            w_rec.level  = TONE_ERROR;
            w_rec.topic  = TOPIC_WITHDRAW;
            w_rec.cycles = r_cnt;
            w_rec.data   = r_lat;
        end else if (w_stbl) begin
            w_rec.level  = TONE_ERROR;
            w_rec.topic  = TOPIC_STBL;
            w_rec.cycles = w_cnt_nxt;
            w_rec.data   = mon_data;
        end else if (w_hs_hold) begin
            w_rec.level  = TONE_INFO;
            w_rec.topic  = TOPIC_HANDSHAKE;
            w_rec.cycles = w_cnt_nxt;
            w_rec.data   = r_lat;
        end else if (w_tmo) begin
            w_rec.level  = TONE_WARN;
            w_rec.topic  = TOPIC_TIMEOUT;
            w_rec.cycles = TMO_CNT;
            w_rec.data   = r_lat;
        end
    end

    // Monitor FSM: tracks the pending hold, its latched payload and length.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_lat   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (mon_valid & ~mon_ready) begin
                        r_state <= ST_HOLD;
                        r_lat   <= mon_data;
                        r_cnt   <= CNT_WIDTH'(1);
                    end
                end
                default: begin
                    if (w_withdraw || w_hs_hold) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (w_stbl) begin
                        // The changed payload becomes the new reference.
                        r_lat <= mon_data;
                        if (mon_ready) begin
                            r_state <= ST_IDLE;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= w_cnt_nxt;
                        end
                    end else begin
                        r_cnt <= w_cnt_nxt;
                        if (w_tmo) r_state <= ST_STUCK;
                    end
                end
            endcase
        end
    end

    // Free-running timestamp, wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_ts <= '0;
        else     r_ts <= r_ts + TS_WIDTH'(1);
    end

    assign w_pop  = evt_ready & evt_valid;
    assign w_push = w_evt & (~w_full | w_pop);

    // Saturating count of events that found the FIFO full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                r_drop <= '0;
        else if (w_evt && !w_push && !(&r_drop)) r_drop <= r_drop + CNT_WIDTH'(1);
    end

    event_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_rec),
        .i_pop   (w_pop),
        .o_data  (w_head_bits),
        .o_valid (evt_valid),
        .o_full  (w_full)
    );

    assign w_head     = event_t'(w_head_bits);
    assign evt_level  = w_head.level;
    assign evt_topic  = w_head.topic;
    assign evt_time   = w_head.tstamp;
    assign evt_cycles = w_head.cycles;
    assign evt_data   = w_head.data;
    assign drop_count = r_drop;

endmodule

// File: tb/tb_hs_monitor.sv
// Directed self-checking bench for hs_monitor with default parameters.
module tb_hs_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mon_valid = 1'b0;
    logic        mon_ready = 1'b0;
    logic [7:0]  mon_data = 8'h00;
    logic        evt_valid;
    logic        evt_ready = 1'b0;
    logic [2:0]  evt_level;
    logic [1:0]  evt_topic;
    logic [31:0] evt_time;
    logic [15:0] evt_cycles;
    logic [7:0]  evt_data;
    logic [15:0] drop_count;

    int checks   = 0;
    int failures = 0;
    int tb_t;
    int t0;

    localparam int L_INFO = 2, L_WARN = 3, L_ERROR = 4;
    localparam int T_HS = 0, T_STBL = 1, T_WD = 2, T_TMO = 3;

    hs_monitor dut (
        .clk        (clk),
        .rst        (rst),
        .mon_valid  (mon_valid),
        .mon_ready  (mon_ready),
        .mon_data   (mon_data),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_level  (evt_level),
        .evt_topic  (evt_topic),
        .evt_time   (evt_time),
        .evt_cycles (evt_cycles),
        .evt_data   (evt_data),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    // Reference cycle count since reset release.
    always @(posedge clk or posedge rst) begin
        if (rst) tb_t <= 0;
        else     tb_t <= tb_t + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply inputs at a falling edge and move to the next falling edge.
    task automatic drive(input logic v, input logic r, input logic [7:0] d);
        mon_valid = v;
        mon_ready = r;
        mon_data  = d;
        @(negedge clk);
    endtask

    task automatic expect_head(input string tag, input int lvl, input int top,
                               input int tm, input int cy, input int d);
        chk({tag, ".valid"},  {63'd0, evt_valid}, 64'd1);
        chk({tag, ".level"},  {61'd0, evt_level}, 64'(lvl));
        chk({tag, ".topic"},  {62'd0, evt_topic}, 64'(top));
        chk({tag, ".time"},   {32'd0, evt_time},  64'(tm));
        chk({tag, ".cycles"}, {48'd0, evt_cycles}, 64'(cy));
        chk({tag, ".data"},   {56'd0, evt_data},  64'(d));
    endtask

    task automatic pop();
        mon_valid = 1'b0;
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst.evt_valid", {63'd0, evt_valid}, 64'd0);
        chk("rst.drop", {48'd0, drop_count}, 64'd0);
        chk("rst.level", {61'd0, evt_level}, 64'd0);
        chk("rst.topic", {62'd0, evt_topic}, 64'd0);
        chk("rst.time", {32'd0, evt_time}, 64'd0);
        chk("rst.cycles", {48'd0, evt_cycles}, 64'd0);
        chk("rst.data", {56'd0, evt_data}, 64'd0);
        rst = 1'b0;

        // Immediate handshake at timestamp 5
        repeat (5) drive(1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b1, 8'hA5);
        mon_valid = 1'b0;
        expect_head("hs_imm", L_INFO, T_HS, 5, 1, 8'hA5);
        pop();
        chk("hs_imm.empty", {63'd0, evt_valid}, 64'd0);

        // Stalled handshake, 3 wait cycles
        t0 = tb_t;
        repeat (3) drive(1'b1, 1'b0, 8'h3C);
        drive(1'b1, 1'b1, 8'h3C);
        drive(1'b0, 1'b0, 8'h00);
        expect_head("hs_stall", L_INFO, T_HS, t0 + 3, 4, 8'h3C);
        pop();
        chk("hs_stall.single", {63'd0, evt_valid}, 64'd0);

        // Payload change during stall
        t0 = tb_t;
        drive(1'b1, 1'b0, 8'h11);
        drive(1'b1, 1'b0, 8'h22);
        drive(1'b1, 1'b0, 8'h22);
        drive(1'b1, 1'b1, 8'h22);
        drive(1'b0, 1'b0, 8'h00);
        expect_head("stbl", L_ERROR, T_STBL, t0 + 1, 2, 8'h22);
        pop();
        expect_head("stbl_hs", L_INFO, T_HS, t0 + 3, 4, 8'h22);
        pop();
        chk("stbl.empty", {63'd0, evt_valid}, 64'd0);

        // Timeout then withdrawal
        t0 = tb_t;
        repeat (20) drive(1'b1, 1'b0, 8'h5A);
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        expect_head("tmo", L_WARN, T_TMO, t0 + 15, 16, 8'h5A);
        pop();
        expect_head("wd", L_ERROR, T_WD, t0 + 20, 20, 8'h5A);
        pop();
        chk("tmo.no_second", {63'd0, evt_valid}, 64'd0);

        // FIFO full and drop counting
        t0 = tb_t;
        for (int i = 1; i <= 6; i++) drive(1'b1, 1'b1, 8'(i));
        mon_valid = 1'b0;
        chk("full.drop", {48'd0, drop_count}, 64'd2);
        expect_head("full.head", L_INFO, T_HS, t0, 1, 1);
        evt_ready = 1'b1;
        drive(1'b1, 1'b1, 8'h07);
        evt_ready = 1'b0;
        mon_valid = 1'b0;
        chk("full.pop_push_drop", {48'd0, drop_count}, 64'd2);
        chk("full.h2", {56'd0, evt_data}, 64'd2);
        pop();
        chk("full.h3", {56'd0, evt_data}, 64'd3);
        pop();
        chk("full.h4", {56'd0, evt_data}, 64'd4);
        pop();
        expect_head("full.h7", L_INFO, T_HS, t0 + 6, 1, 7);
        pop();
        chk("full.empty", {63'd0, evt_valid}, 64'd0);

        // Reset in the middle of a hold
        drive(1'b1, 1'b0, 8'h77);
        drive(1'b1, 1'b0, 8'h77);
        mon_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst.evt_valid", {63'd0, evt_valid}, 64'd0);
        chk("midrst.drop", {48'd0, drop_count}, 64'd0);
        rst = 1'b0;
        drive(1'b1, 1'b1, 8'h99);
        drive(1'b0, 1'b0, 8'h00);
        expect_head("midrst.hs", L_INFO, T_HS, 0, 1, 8'h99);
        pop();
        chk("midrst.no_withdraw", {63'd0, evt_valid}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
